status_arb_ctrl: RTL and testbench
==================================

Name: status_arb_ctrl

Overview:
Round-robin arbiter and sequencer that shares one status-capture register among NREQ requesters, each presenting a DW-bit status word. Grants one requester at a time, holds the grant for a fixed settle window, captures that requester's word into the shared register, then presents it on a valid/ready output. It sits in front of the status-combining datapath and sequences which source drives it; enable/debug select the operating mode.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 9, status word width per requester
SRCW, 2, width of source index output (ceil log2 NREQ, minimum 1)
HOLD, 3, grant settle cycles before capture (1..15)

Ports:
sysclk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-high
enable  in  1  1 = new arbitrations allowed
debug  in  1  1 = fixed priority (lowest index wins) instead of round-robin
req  in  NREQ  per-requester request, level, held until granted
req_data  in  NREQ*DW  requester i word at bits [i*DW+DW-1 : i*DW]
gnt  out  NREQ  one-hot grant, registered
busy  out  1  high whenever state is not IDLE
out_valid  out  1  captured word available
out_ready  in  1  consumer accepts word
out_data  out  DW  captured word
out_src  out  SRCW  index of captured requester
arb_cnt  out  8  completed transfers, wraps 255->0

Behaviour:
- Reset (asynchronous, active-high, any time including mid-transfer): state=IDLE, gnt=0, busy=0, out_valid=0, out_data=0, out_src=0, arb_cnt=0, rr pointer=NREQ-1 (so requester 0 has first priority). Deassertion takes effect on next rising sysclk.
- States: IDLE, GRANT, DRAIN.
- IDLE: on edge with enable=1 and req!=0, choose winner, set gnt one-hot, load hold counter=HOLD-1, go GRANT. Otherwise stay, gnt=0.
- Winner, round-robin (debug=0): first asserted req scanning ptr+1, ptr+2, ... modulo NREQ. Winner, debug=1: lowest asserted index. debug sampled only at the arbitration edge.
- GRANT: gnt held constant. Counter decrements each edge. Edge where counter==0 and req[winner]=1: out_data <= req_data slice of winner, out_src <= winner, out_valid <= 1, gnt <= 0, go DRAIN.
- Abort: any GRANT edge with req[winner]=0: gnt <= 0, go IDLE, no capture, arb_cnt unchanged, ptr <= winner (requester loses its turn).
- DRAIN: out_valid, out_data, out_src stable until handshake. Edge with out_ready=1: out_valid <= 0, ptr <= winner, arb_cnt <= arb_cnt+1 (mod 256), go IDLE. No bypass: next gnt rises earliest the edge after the handshake edge... i.e. IDLE spends at least one cycle.
- Latency: req seen at edge E -> gnt high after E -> out_valid high after edge E+HOLD. Minimum transfer period HOLD+2 cycles with out_ready tied high.
- enable=0 only blocks arbitration in IDLE; a transfer in GRANT/DRAIN completes normally.
- req changes on non-winning lines during GRANT/DRAIN ignored until next IDLE.
- gnt never has more than one bit set; gnt and out_valid never high together.
- busy = (state != IDLE), registered with state.

Test Plan:
- Reset then req=4'b0001, enable=1, out_ready=1, req_data word0=9'h1A5 -> gnt=0001 for 3 cycles, out_valid one cycle with out_data=9'h1A5, out_src=0, arb_cnt=1.
- req=4'b1111 held, debug=0, out_ready=1 -> grant order 0,1,2,3,0; out_src follows; arb_cnt=5 after five transfers; gnt rises every 5 cycles.
- Same with debug=1 -> every grant to requester 0, out_src=0 each time.
- req=4'b0110, deassert req[1] one cycle after gnt=0010 -> gnt drops, no out_valid, next grant goes to requester 2, arb_cnt unchanged.
- out_ready=0 for 10 cycles in DRAIN with req_data changing -> out_valid, out_data, out_src stable; no gnt; on out_ready=1 single handshake, arb_cnt +1.
- Assert reset asynchronously mid-GRANT (between edges) -> gnt, busy, out_valid fall immediately; after release requester 0 wins first; arb_cnt=0. Also run 256 transfers -> arb_cnt wraps to 0.

Source files
------------

// File: rtl/status_arb_ctrl.sv
// Round-robin / fixed-priority arbiter that time-shares one status capture
// register among NREQ requesters and presents the captured word on valid/ready.
`timescale 1ns/1ps
module status_arb_ctrl #(
  parameter int NREQ = 4,
  parameter int DW   = 9,
  parameter int SRCW = 2,
  parameter int HOLD = 3
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               enable,
  input  logic               debug,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [SRCW-1:0]    out_src,
  output logic [7:0]         arb_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [NREQ-1:0]   r_gnt,       w_gnt_nxt;
  logic [3:0]        r_hold,      w_hold_nxt;
  logic [SRCW-1:0]   r_win,       w_win_nxt;
  logic [SRCW-1:0]   r_ptr,       w_ptr_nxt;
  logic              r_busy;
  logic              r_out_valid, w_out_valid_nxt;
  logic [DW-1:0]     r_out_data,  w_out_data_nxt;
  logic [SRCW-1:0]   r_out_src,   w_out_src_nxt;
  logic [7:0]        r_arb_cnt,   w_arb_cnt_nxt;

  logic [SRCW-1:0]   w_pick;
  logic [NREQ-1:0]   w_pick_oh;
  logic [DW-1:0]     w_win_data;
  logic              w_win_req;

  // Winner search: loops run from lowest to highest priority so the last hit wins.
  always_comb begin
    int              v_idx;
    logic [SRCW-1:0] v_sel;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_pick = '0;
    v_idx  = 0;
    v_sel  = '0;
    if (debug) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        v_sel = SRCW'(i);
        if (req[v_sel]) w_pick = v_sel;
      end
    end else begin
      for (int k = NREQ; k >= 1; k--) begin
        v_idx = (int'(r_ptr) + k) % NREQ;
        v_sel = SRCW'(v_idx);
        if (req[v_sel]) w_pick = v_sel;
      end
    end
  end

  always_comb begin
    w_pick_oh  = '0;
    w_win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_pick_oh[i] = (w_pick == SRCW'(i));
      if (r_win == SRCW'(i)) w_win_data = req_data[i*DW +: DW];
    end
  end

  // The grant vector is one-hot on the winner throughout GRANT.
  assign w_win_req = |(req & r_gnt);

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_hold_nxt      = r_hold;
    w_win_nxt       = r_win;
    w_ptr_nxt       = r_ptr;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_src_nxt   = r_out_src;
    w_arb_cnt_nxt   = r_arb_cnt;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (enable && (|req)) begin
          w_gnt_nxt   = w_pick_oh;
          w_win_nxt   = w_pick;
          w_hold_nxt  = 4'(HOLD - 1);
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!w_win_req) begin
          // Requester dropped out: it forfeits its turn.
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_win;
          w_state_nxt = ST_IDLE;
        end else if (r_hold == 4'd0) begin
          w_out_data_nxt  = w_win_data;
          w_out_src_nxt   = r_win;
          w_out_valid_nxt = 1'b1;
          w_gnt_nxt       = '0;
          w_state_nxt     = ST_DRAIN;
        end else begin
          w_hold_nxt = r_hold - 4'd1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_ptr_nxt       = r_win;
          w_arb_cnt_nxt   = r_arb_cnt + 8'd1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_hold      <= '0;
      r_win       <= '0;
      r_ptr       <= SRCW'(NREQ - 1);
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_arb_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_hold      <= w_hold_nxt;
      r_win       <= w_win_nxt;
      r_ptr       <= w_ptr_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_src   <= w_out_src_nxt;
      r_arb_cnt   <= w_arb_cnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign arb_cnt   = r_arb_cnt;

endmodule

// File: tb/tb_status_arb_ctrl.sv
// Self-checking bench for status_arb_ctrl: directed steps plus random transfers
// checked against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_status_arb_ctrl;
  localparam int NREQ = 4;
  localparam int DW   = 9;
  localparam int SRCW = 2;
  localparam int HOLD = 3;

  logic               sysclk = 1'b0;
  logic               reset;
  logic               enable;
  logic               debug;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [SRCW-1:0]    out_src;
  logic [7:0]         arb_cnt;

  int                 n_cmp  = 0;
  int                 n_fail = 0;
  int                 m_ptr;
  logic [7:0]         m_cnt;
  int                 w_exp;

  status_arb_ctrl #(.NREQ(NREQ), .DW(DW), .SRCW(SRCW), .HOLD(HOLD)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .enable    (enable),
    .debug     (debug),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .arb_cnt   (arb_cnt)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  // Reference winner: debug -> lowest set bit; otherwise first set bit after ptr, circularly.
  function automatic int pick(input logic [NREQ-1:0] r, input int ptr, input bit dbg);
    logic [2*NREQ-1:0] dbl;
    int                start;
    int                res;
    bit                found;
    res   = -1;
    found = 1'b0;
    if (dbg) begin
      for (int i = 0; i < NREQ; i++)
        if (!found && r[i]) begin res = i; found = 1'b1; end
    end else begin
      start = (ptr + 1) % NREQ;
      dbl   = {r, r} >> start;
      for (int p = 0; p < NREQ; p++)
        if (!found && dbl[p]) begin res = (start + p) % NREQ; found = 1'b1; end
    end
    return res;
  endfunction

  // One complete transfer starting from IDLE; stall = cycles of out_ready=0 in DRAIN.
  task automatic do_xfer(input logic [NREQ-1:0] r, input bit dbg, input bit rnd,
                         input int stall, input bit en_after);
    int              w;
    logic [NREQ-1:0] exp_g;
    logic [DW-1:0]   exp_d;
    req       = r;
    debug     = dbg;
    enable    = 1'b1;
    out_ready = (stall == 0);
    if (rnd) rand_data();
    w     = pick(r, m_ptr, dbg);
    exp_g = NREQ'(1) << w;
    exp_d = req_data[w*DW +: DW];
    tick();
    check("gnt_rise", gnt, exp_g);
    check("busy_in_grant", busy, 1);
    debug  = ~dbg;
    enable = en_after;
    for (int c = 1; c < HOLD; c++) begin
      tick();
      check("gnt_hold", gnt, exp_g);
      check("valid_low_in_grant", out_valid, 0);
    end
    tick();
    check("out_valid_rise", out_valid, 1);
    check("out_data", out_data, exp_d);
    check("out_src", out_src, w);
    check("gnt_low_in_drain", gnt, 0);
    for (int s = 0; s < stall; s++) begin
      rand_data();
      req = NREQ'($urandom);
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, exp_d);
      check("stall_src", out_src, w);
      check("stall_no_gnt", gnt, 0);
      check("stall_busy", busy, 1);
    end
    out_ready = 1'b1;
    tick();
    m_cnt = m_cnt + 8'd1;
    m_ptr = w;
    check("valid_after_handshake", out_valid, 0);
    check("arb_cnt", arb_cnt, m_cnt);
    check("busy_after_handshake", busy, 0);
    check("gnt_after_handshake", gnt, 0);
  endtask

  initial begin
    enable    = 1'b0;
    debug     = 1'b0;
    out_ready = 1'b0;
    req       = '0;
    req_data  = '0;
    reset     = 1'b0;
    #1 reset  = 1'b1;
    m_ptr     = NREQ - 1;
    m_cnt     = 8'd0;
    #10;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_src", out_src, 0);
    check("rst_cnt", arb_cnt, 0);
    @(negedge sysclk);
    reset = 1'b0;

    // Single requester with a known word.
    req_data[DW-1:0] = 9'h1A5;
    do_xfer(4'b0001, 1'b0, 1'b0, 0, 1'b1);

    // Round-robin rotation with all requesters held.
    for (int n = 0; n < 5; n++) do_xfer(4'b1111, 1'b0, 1'b1, 0, 1'b1);

    // Fixed priority: requester 0 always wins.
    for (int n = 0; n < 3; n++) do_xfer(4'b1111, 1'b1, 1'b1, 0, 1'b1);

    // Abort: winner drops its request one cycle into GRANT.
    req    = 4'b0110;
    debug  = 1'b0;
    enable = 1'b1;
    w_exp  = pick(req, m_ptr, 1'b0);
    tick();
    check("abort_gnt", gnt, NREQ'(1) << w_exp);
    req = req & ~(NREQ'(1) << w_exp);
    tick();
    check("abort_gnt_drop", gnt, 0);
    check("abort_busy", busy, 0);
    check("abort_no_valid", out_valid, 0);
    check("abort_cnt", arb_cnt, m_cnt);
    m_ptr = w_exp;
    do_xfer(4'b0110, 1'b0, 1'b1, 0, 1'b1);

    // Consumer stalls 10 cycles while inputs churn.
    do_xfer(NREQ'($urandom_range(1, 15)), 1'b0, 1'b1, 10, 1'b1);

    // enable drops mid-transfer: transfer completes, then no new arbitration.
    do_xfer(4'b1111, 1'b0, 1'b1, 0, 1'b0);
    req = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("disabled_no_gnt", gnt, 0);
      check("disabled_idle", busy, 0);
    end

    // Asynchronous reset in the middle of GRANT.
    req    = 4'b1111;
    debug  = 1'b0;
    enable = 1'b1;
    tick();
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_gnt", gnt, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_cnt", arb_cnt, 0);
    m_ptr = NREQ - 1;
    m_cnt = 8'd0;
    #3 reset = 1'b0;
    do_xfer(4'b1111, 1'b0, 1'b1, 0, 1'b1);

    // Random traffic; 256 transfers since reset brings the counter back to 0.
    for (int n = 1; n < 256; n++)
      do_xfer(NREQ'($urandom_range(1, 15)), 1'($urandom), 1'b1,
              int'($urandom_range(0, 2)), 1'b1);
    check("arb_cnt_wrap", arb_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
